// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage definitions: PC increment, default widths and the
// {npc, instr} queue entry layout used by IF, ID and the hazard logic.
package if_defs;

  localparam int PC_INCR    = 4;
  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  // Queue entry layout: next-PC in the upper bits, instruction in the lower.
  typedef struct packed {
    logic [AW_DEFAULT-1:0] npc;
    logic [DW_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Prefetch FIFO: power-of-two depth, push/pop/synchronous clear, exposes
// occupancy and the head entry. Clear takes priority over push and pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; clear resets them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential fetch to a one-cycle synchronous
// memory, prefetch queue of {npc, instr}, valid/stall handshake to ID and
// branch redirect that flushes everything buffered or in flight.
module if_fetch_queue
  import if_defs::*;
#(
  parameter int            AW       = AW_DEFAULT,
  parameter int            DW       = DW_DEFAULT,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PCSrc,
  input  logic [AW-1:0] EX_MEM,
  input  logic          id_stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [AW-1:0] npcout,
  output logic [DW-1:0] instrout,
  output logic          if_valid
);

  localparam int            CW        = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] INCR      = AW'(PC_INCR);

  logic [AW-1:0]    pc;
  logic [AW-1:0]    req_pc;
  logic             inflight;
  logic [CW-1:0]    count;
  logic [CW:0]      occupancy;
  logic             issue;
  logic             resp_kill;
  logic             push;
  logic             pop;
  logic [AW+DW-1:0] head;

  // Entries held plus the one outstanding response bound the issue window,
  // so a returning instruction always has a free slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = !PCSrc && (occupancy < DEPTH_OCC);

  // A response landing in a redirect cycle belongs to the old path.
  assign resp_kill = PCSrc && inflight;
  assign push      = inflight && !resp_kill;
  assign pop       = if_valid && !id_stall && !PCSrc;

  // PC, request tracking and the recorded request PC for the next push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= PC_RESET;
      req_pc   <= PC_RESET;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (PCSrc) begin
        pc <= EX_MEM;
      end else if (issue) begin
        pc     <= pc + INCR;
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (PCSrc),
    .push  (push),
    .pop   (pop),
    .din   ({req_pc + INCR, imem_rdata}),
    .dout  (head),
    .count (count)
  );

  assign imem_req  = issue && !rst;
  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign npcout    = if_valid ? head[AW+DW-1:DW] : '0;
  assign instrout  = if_valid ? head[DW-1:0]     : '0;

endmodule
